// File: rtl/iobufds_pkg.sv
// rtl/iobufds_pkg.sv - shared types and pad decode for the differential pad bank
package iobufds_pkg;

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PAD_VALID0  = 2'b00,
    PAD_VALID1  = 2'b01,
    PAD_INVALID = 2'b10
  } pad_code_t;

  // Only a true differential pair is valid; equal legs, X or Z fall through to INVALID.
  function automatic pad_code_t pad_decode(input logic p, input logic n);
    pad_code_t code;
    code = PAD_INVALID;
    if (p == 1'b1 && n == 1'b0) code = PAD_VALID1;
    else if (p == 1'b0 && n == 1'b1) code = PAD_VALID0;
    return code;
  endfunction

endpackage

// File: rtl/iobufds_rx_lane.sv
// rtl/iobufds_rx_lane.sv - one lane: 2-flop synchroniser, glitch filter, sticky fault counter
module iobufds_rx_lane
  import iobufds_pkg::*;
#(
  parameter int FILT_CYCLES  = 3,
  parameter int FAULT_THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_p,
  input  logic pad_n,
  input  logic rx_mode,
  input  logic chk_mode,
  input  logic exp_bit,
  input  logic fault_clr,
  output logic o,
  output logic fault
);

  localparam int FCW = $clog2(FILT_CYCLES + 1);
  localparam int TCW = $clog2(FAULT_THRESH + 1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_CYCLES);
  localparam logic [TCW-1:0] FLT_MAX  = TCW'(FAULT_THRESH);
  localparam logic [TCW-1:0] FLT_LAST = TCW'(FAULT_THRESH - 1);

  pad_code_t      sync1, sync2;
  logic [FCW-1:0] filt_cnt;
  logic           last_val;
  logic [TCW-1:0] flt_cnt;
  logic           samp_val;
  logic           bad;
  logic           active;
  logic           hit;

  assign samp_val = (sync2 == PAD_VALID1);
  assign bad      = (sync2 == PAD_INVALID) || (chk_mode && (samp_val != exp_bit));
  assign active   = rx_mode || chk_mode;
  assign hit      = active && bad && (flt_cnt >= FLT_LAST);

  // Two-flop synchroniser on the decoded pad code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= PAD_VALID0;
      sync2 <= PAD_VALID0;
    end else begin
      sync1 <= pad_decode(pad_p, pad_n);
      sync2 <= sync1;
    end
  end

  // Glitch filter: O follows only after FILT_CYCLES identical valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      last_val <= 1'b0;
      o        <= 1'b0;
    end else if (sync2 == PAD_INVALID) begin
      filt_cnt <= '0;
    end else if (filt_cnt == '0 || samp_val != last_val) begin
      filt_cnt <= FCW'(1);
      last_val <= samp_val;
      if (FILT_CYCLES == 1) o <= samp_val;
    end else if (filt_cnt != FILT_MAX) begin
      filt_cnt <= filt_cnt + 1'b1;
      if (filt_cnt == FILT_MAX - 1'b1) o <= samp_val;
    end
  end

  // Consecutive-bad counter; saturates at the threshold, cleared by any good sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
    end else if (fault_clr || !active || !bad) begin
      flt_cnt <= '0;
    end else if (flt_cnt != FLT_MAX) begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // Sticky fault flag; a coincident set beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault <= 1'b0;
    else if (hit) fault <= 1'b1;
    else if (fault_clr) fault <= 1'b0;
  end

endmodule

// File: rtl/iobufds_bank.sv
// rtl/iobufds_bank.sv - differential pad bank top; optional TX loopback check via IOBUFDS_BANK_LOOPBACK_CHECK_EN
module iobufds_bank
  import iobufds_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TURN_CYCLES  = 2,
  parameter int FILT_CYCLES  = 3,
  parameter int FAULT_THRESH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  input  logic             FAULT_CLR,
  output logic [WIDTH-1:0] O,
  inout  wire  [WIDTH-1:0] IO,
  inout  wire  [WIDTH-1:0] IOB,
  output logic [WIDTH-1:0] FAULT,
  output logic             DRIVING,
  output logic             BUSY
);

  localparam int TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYCLES - 1);

  state_t           state, state_nxt;
  logic [TCW-1:0]   turn_cnt, turn_nxt;
  logic [WIDTH-1:0] i_q;
  logic             chk_mode;
  logic [WIDTH-1:0] exp_bits;

  // Direction state and dead-time counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RX;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_nxt;
    end
  end

  // Break-before-make turnaround; TURN_TX may abort, TURN_RX always runs to completion.
  always_comb begin
    state_nxt = state;
    turn_nxt  = turn_cnt;
    case (state)
      RX: begin
        if (!T) begin
          state_nxt = TURN_TX;
          turn_nxt  = TURN_LOAD;
        end
      end
      TURN_TX: begin
        if (T) state_nxt = RX;
        else if (turn_cnt == '0) state_nxt = TX;
        else turn_nxt = turn_cnt - 1'b1;
      end
      TX: begin
        if (T) begin
          state_nxt = TURN_RX;
          turn_nxt  = TURN_LOAD;
        end
      end
      TURN_RX: begin
        if (turn_cnt == '0) state_nxt = RX;
        else turn_nxt = turn_cnt - 1'b1;
      end
      default: state_nxt = RX;
    endcase
  end

  // Transmit data register, one cycle from I to the pads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) i_q <= '0;
    else i_q <= I;
  end

  assign DRIVING = (state == TX);
  assign BUSY    = (state == TURN_TX) || (state == TURN_RX);
  assign IO      = DRIVING ? i_q  : {WIDTH{1'bz}};
  assign IOB     = DRIVING ? ~i_q : {WIDTH{1'bz}};

`ifdef IOBUFDS_BANK_LOOPBACK_CHECK_EN
  logic [1:0]       settle;
  logic [WIDTH-1:0] iq_d1, iq_d2;

  // Align transmitted data with the synchroniser and wait for it to fill after TX entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      settle <= '0;
      iq_d1  <= '0;
      iq_d2  <= '0;
    end else begin
      iq_d1 <= i_q;
      iq_d2 <= iq_d1;
      if (state != TX) settle <= '0;
      else if (settle != 2'd2) settle <= settle + 1'b1;
    end
  end

  assign chk_mode = (state == TX) && (settle == 2'd2);
  assign exp_bits = iq_d2;
`else
  assign chk_mode = 1'b0;
  assign exp_bits = '0;
`endif

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    iobufds_rx_lane #(
      .FILT_CYCLES (FILT_CYCLES),
      .FAULT_THRESH(FAULT_THRESH)
    ) u_lane (
      .clk      (CLK),
      .rst_n    (RST_N),
      .pad_p    (IO[k]),
      .pad_n    (IOB[k]),
      .rx_mode  (state == RX),
      .chk_mode (chk_mode),
      .exp_bit  (exp_bits[k]),
      .fault_clr(FAULT_CLR),
      .o        (O[k]),
      .fault    (FAULT[k])
    );
  end

endmodule

// File: tb/tb_iobufds_bank.sv
// tb/tb_iobufds_bank.sv - directed self-checking bench for iobufds_bank
module tb_iobufds_bank;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] I;
  logic       T;
  logic       FAULT_CLR;
  logic [7:0] O;
  logic [7:0] FAULT;
  logic       DRIVING;
  logic       BUSY;
  wire  [7:0] io_w;
  wire  [7:0] iob_w;

  logic [7:0] ext_oe;
  logic [7:0] ext_p;
  logic [7:0] ext_n;

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 8; k++) begin : g_ext
    assign io_w[k]  = ext_oe[k] ? ext_p[k] : 1'bz;
    assign iob_w[k] = ext_oe[k] ? ext_n[k] : 1'bz;
  end

  iobufds_bank #(
    .WIDTH(8), .TURN_CYCLES(2), .FILT_CYCLES(3), .FAULT_THRESH(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .I(I), .T(T), .FAULT_CLR(FAULT_CLR),
    .O(O), .IO(io_w), .IOB(iob_w), .FAULT(FAULT), .DRIVING(DRIVING), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_pads(input logic [7:0] v);
    ext_oe = 8'hFF;
    ext_p  = v;
    ext_n  = ~v;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; T = 1'b1; I = 8'h00; FAULT_CLR = 1'b0;
    drive_pads(8'h00);
    #3;
    total++; if (O !== 8'h00)     begin bad++; $display("FAIL reset_o got=%h exp=00", O); end
    total++; if (FAULT !== 8'h00) begin bad++; $display("FAIL reset_fault got=%h exp=00", FAULT); end
    total++; if (DRIVING !== 1'b0) begin bad++; $display("FAIL reset_driving got=%b exp=0", DRIVING); end
    total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    tick(2);
    RST_N = 1'b1;
    tick(6);
  endtask

  task automatic test_rx_latency;
    drive_pads(8'h01);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      total++;
      if (O[0] !== (k == 5)) begin
        bad++; $display("FAIL rx_latency edge=%0d got=%b exp=%b", k, O[0], (k == 5));
      end
    end
    total++; if (FAULT !== 8'h00) begin bad++; $display("FAIL rx_fault got=%h exp=00", FAULT); end
  endtask

  task automatic test_tx;
    I = 8'hA5; T = 1'b0;
    tick(1);
    ext_oe = 8'h00;
    total++; if (BUSY !== 1'b1 || DRIVING !== 1'b0) begin bad++; $display("FAIL turn_tx1 busy=%b drv=%b exp busy=1 drv=0", BUSY, DRIVING); end
    tick(1);
    total++; if (BUSY !== 1'b1 || DRIVING !== 1'b0) begin bad++; $display("FAIL turn_tx2 busy=%b drv=%b exp busy=1 drv=0", BUSY, DRIVING); end
    tick(1);
    total++; if (BUSY !== 1'b0 || DRIVING !== 1'b1) begin bad++; $display("FAIL tx_enter busy=%b drv=%b exp busy=0 drv=1", BUSY, DRIVING); end
    total++; if (io_w !== 8'hA5 || iob_w !== 8'h5A) begin bad++; $display("FAIL tx_pads io=%h iob=%h exp io=a5 iob=5a", io_w, iob_w); end
    I = 8'h3C;
    total++; if (io_w !== 8'hA5) begin bad++; $display("FAIL tx_latency_hold io=%h exp=a5", io_w); end
    tick(1);
    total++; if (io_w !== 8'h3C || iob_w !== 8'hC3) begin bad++; $display("FAIL tx_latency io=%h iob=%h exp io=3c iob=c3", io_w, iob_w); end
    tick(6);
    total++; if (O !== 8'h3C) begin bad++; $display("FAIL tx_o_track got=%h exp=3c", O); end
    total++; if (FAULT !== 8'h00) begin bad++; $display("FAIL tx_fault got=%h exp=00", FAULT); end
    T = 1'b1;
    tick(1);
    drive_pads(8'h01);
    total++; if (BUSY !== 1'b1 || DRIVING !== 1'b0) begin bad++; $display("FAIL turn_rx1 busy=%b drv=%b exp busy=1 drv=0", BUSY, DRIVING); end
    T = 1'b0;
    tick(1);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL turn_rx2 busy=%b exp=1", BUSY); end
    T = 1'b1;
    tick(1);
    total++; if (BUSY !== 1'b0 || DRIVING !== 1'b0) begin bad++; $display("FAIL back_to_rx busy=%b drv=%b exp busy=0 drv=0", BUSY, DRIVING); end
    tick(6);
    total++; if (O !== 8'h01) begin bad++; $display("FAIL rx_after_tx got=%h exp=01", O); end
  endtask

  task automatic test_abort;
    T = 1'b0;
    tick(1);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b exp=1", BUSY); end
    T = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++;
      if (BUSY !== 1'b0 || DRIVING !== 1'b0) begin
        bad++; $display("FAIL abort_rx cyc=%0d busy=%b drv=%b exp busy=0 drv=0", k, BUSY, DRIVING);
      end
    end
  endtask

  task automatic test_fault;
    ext_oe[3] = 1'b0;
    tick(4);
    ext_oe[3] = 1'b1;
    tick(1);
    total++; if (FAULT !== 8'h00) begin bad++; $display("FAIL fault_early got=%h exp=00", FAULT); end
    tick(1);
    total++; if (FAULT !== 8'h08) begin bad++; $display("FAIL fault_set got=%h exp=08", FAULT); end
    tick(5);
    total++; if (FAULT !== 8'h08) begin bad++; $display("FAIL fault_sticky got=%h exp=08", FAULT); end
    total++; if (O !== 8'h01) begin bad++; $display("FAIL fault_o_hold got=%h exp=01", O); end
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
    total++; if (FAULT !== 8'h00) begin bad++; $display("FAIL fault_clr got=%h exp=00", FAULT); end
    ext_oe[3] = 1'b0;
    tick(3);
    ext_oe[3] = 1'b1;
    tick(8);
    total++; if (FAULT !== 8'h00) begin bad++; $display("FAIL fault_short_burst got=%h exp=00", FAULT); end
  endtask

  task automatic test_glitch;
    drive_pads(8'h02);
    tick(8);
    total++; if (O !== 8'h02) begin bad++; $display("FAIL glitch_pre got=%h exp=02", O); end
    drive_pads(8'h00);
    tick(1);
    drive_pads(8'h02);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      total++;
      if (O[1] !== 1'b1) begin bad++; $display("FAIL glitch cyc=%0d got=%b exp=1", k, O[1]); end
    end
  endtask

  task automatic test_reset_mid_tx;
    I = 8'h96; T = 1'b0;
    tick(1);
    ext_oe = 8'h00;
    tick(2);
    total++; if (DRIVING !== 1'b1 || io_w !== 8'h96) begin bad++; $display("FAIL pre_reset_tx drv=%b io=%h exp drv=1 io=96", DRIVING, io_w); end
    #2;
    RST_N = 1'b0;
    #1;
    total++; if (DRIVING !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL async_reset drv=%b busy=%b exp 0 0", DRIVING, BUSY); end
    total++; if (O !== 8'h00) begin bad++; $display("FAIL async_reset_o got=%h exp=00", O); end
    T = 1'b1;
    drive_pads(8'h00);
    tick(2);
    RST_N = 1'b1;
    tick(2);
    total++; if (DRIVING !== 1'b0) begin bad++; $display("FAIL post_reset_rx drv=%b exp=0", DRIVING); end
  endtask

  initial begin
    ext_oe = 8'h00; ext_p = 8'h00; ext_n = 8'hFF;
    test_reset;
    test_rx_latency;
    test_tx;
    test_abort;
    test_fault;
    test_glitch;
    test_reset_mid_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
